// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU control codes, opcode/funct constants and the decode bundle type.
package alu_issue_stage_pkg;

  // ALU control codes seen by the EX stage
  localparam logic [2:0] CtlAnd = 3'b000;
  localparam logic [2:0] CtlOr  = 3'b001;
  localparam logic [2:0] CtlAdd = 3'b010;
  localparam logic [2:0] CtlSub = 3'b110;
  localparam logic [2:0] CtlSlt = 3'b111;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef struct packed {
    logic [2:0] ctl;
    logic       use_imm;    // B comes from the immediate
    logic       imm_zext;   // zero- rather than sign-extend the immediate
    logic       dest_rt;    // write-back register is rt rather than rd
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational opcode/funct decode into ALU control code and pipeline control bits.
module alu_ctl_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // Decode table; anything unrecognised falls out as illegal with ctl=ADD and no side effects
  always_comb begin
    dec     = '0;
    dec.ctl = CtlAdd;
    unique case (opcode)
      OpRtype: begin
        dec.reg_write = 1'b1;
        unique case (funct)
          FnAdd:   dec.ctl = CtlAdd;
          FnSub:   dec.ctl = CtlSub;
          FnAnd:   dec.ctl = CtlAnd;
          FnOr:    dec.ctl = CtlOr;
          FnSlt:   dec.ctl = CtlSlt;
          default: begin
            dec.reg_write = 1'b0;
            dec.illegal   = 1'b1;
          end
        endcase
      end
      OpAddi: begin
        dec.ctl = CtlAdd; dec.use_imm = 1'b1; dec.dest_rt = 1'b1; dec.reg_write = 1'b1;
      end
      OpSlti: begin
        dec.ctl = CtlSlt; dec.use_imm = 1'b1; dec.dest_rt = 1'b1; dec.reg_write = 1'b1;
      end
      OpAndi: begin
        dec.ctl = CtlAnd; dec.use_imm = 1'b1; dec.imm_zext = 1'b1;
        dec.dest_rt = 1'b1; dec.reg_write = 1'b1;
      end
      OpOri: begin
        dec.ctl = CtlOr; dec.use_imm = 1'b1; dec.imm_zext = 1'b1;
        dec.dest_rt = 1'b1; dec.reg_write = 1'b1;
      end
      OpLw: begin
        dec.ctl = CtlAdd; dec.use_imm = 1'b1; dec.dest_rt = 1'b1;
        dec.reg_write = 1'b1; dec.mem_read = 1'b1;
      end
      OpSw: begin
        dec.ctl = CtlAdd; dec.use_imm = 1'b1; dec.mem_write = 1'b1;
      end
      OpBeq: begin
        dec.ctl = CtlSub; dec.branch = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID-side ALU issue: decode, operand forwarding and the ID/EX pipeline register.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned RW   = 5,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [5:0]      id_opcode,
  input  logic [5:0]      id_funct,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_rd,
  input  logic [DW-1:0]   id_rs_data,
  input  logic [DW-1:0]   id_rt_data,
  input  logic [15:0]     id_imm,
  input  logic            flush,
  input  logic            exm_wen,
  input  logic [RW-1:0]   exm_rd,
  input  logic [DW-1:0]   exm_data,
  input  logic            mwb_wen,
  input  logic [RW-1:0]   mwb_rd,
  input  logic [DW-1:0]   mwb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [2:0]      ex_ctl,
  output logic [DW-1:0]   ex_data_a,
  output logic [DW-1:0]   ex_data_b,
  output logic [DW-1:0]   ex_store_data,
  output logic [RW-1:0]   ex_dest,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_illegal,
  output logic [CNTW-1:0] issued_cnt,
  output logic [CNTW-1:0] illegal_cnt
);

  localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

  dec_t dec;

  alu_ctl_decode u_decode (
    .opcode (id_opcode),
    .funct  (id_funct),
    .dec    (dec)
  );

  logic            valid_q, valid_d;
  logic [2:0]      ctl_q, ctl_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d, st_q, st_d;
  logic [RW-1:0]   dest_q, dest_d;
  logic            rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, br_q, br_d, ill_q, ill_d;
  logic [CNTW-1:0] iss_q, iss_d, ilc_q, ilc_d;

  logic            capture;
  logic [DW-1:0]   fwd_a, fwd_b, imm_ext;
  logic [RW-1:0]   dest;

  assign id_ready = !valid_q || ex_ready;
  assign capture  = id_valid && id_ready;

  // Operand forwarding: EX/MEM has the younger result, so it beats MEM/WB; r0 never forwards
  always_comb begin
    if (exm_wen && exm_rd == id_rs && id_rs != '0)      fwd_a = exm_data;
    else if (mwb_wen && mwb_rd == id_rs && id_rs != '0) fwd_a = mwb_data;
    else                                                fwd_a = id_rs_data;
    if (exm_wen && exm_rd == id_rt && id_rt != '0)      fwd_b = exm_data;
    else if (mwb_wen && mwb_rd == id_rt && id_rt != '0) fwd_b = mwb_data;
    else                                                fwd_b = id_rt_data;
  end

  // Immediate extension and write-back register selection
  always_comb begin
    imm_ext = dec.imm_zext ? {{(DW-16){1'b0}}, id_imm} : {{(DW-16){id_imm[15]}}, id_imm};
    dest    = dec.dest_rt ? id_rt : id_rd;
  end

  // ID/EX next state: flush beats capture; a drained slot only drops valid
  always_comb begin
    valid_d = valid_q;
    ctl_d   = ctl_q;
    a_d     = a_q;
    b_d     = b_q;
    st_d    = st_q;
    dest_d  = dest_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    br_d    = br_q;
    ill_d   = ill_q;
    iss_d   = iss_q;
    ilc_d   = ilc_q;
    if (flush) begin
      valid_d = 1'b0;
      ctl_d   = '0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      br_d    = 1'b0;
      ill_d   = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      ctl_d   = dec.ctl;
      a_d     = fwd_a;
      b_d     = dec.use_imm ? imm_ext : fwd_b;
      st_d    = fwd_b;
      dest_d  = dest;
      rw_d    = dec.reg_write && (dest != '0);
      mr_d    = dec.mem_read;
      mw_d    = dec.mem_write;
      br_d    = dec.branch;
      ill_d   = dec.illegal;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end
    // Killed captures still count as issued
    if (capture) begin
      iss_d = iss_q + CntOne;
      if (dec.illegal) ilc_d = ilc_q + CntOne;
    end
  end

  // ID/EX pipeline register and event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      st_q    <= '0;
      dest_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
      iss_q   <= '0;
      ilc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      st_q    <= st_d;
      dest_q  <= dest_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      br_q    <= br_d;
      ill_q   <= ill_d;
      iss_q   <= iss_d;
      ilc_q   <= ilc_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_ctl        = ctl_q;
  assign ex_data_a     = a_q;
  assign ex_data_b     = b_q;
  assign ex_store_data = st_q;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = rw_q;
  assign ex_mem_read   = mr_q;
  assign ex_mem_write  = mw_q;
  assign ex_branch     = br_q;
  assign ex_illegal    = ill_q;
  assign issued_cnt    = iss_q;
  assign illegal_cnt   = ilc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        flush;
  logic        exm_wen, mwb_wen;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_data, mwb_data;
  logic        ex_valid, ex_ready;
  logic [2:0]  ex_ctl;
  logic [31:0] ex_data_a, ex_data_b, ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
  logic [31:0] issued_cnt, illegal_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_opcode     (id_opcode),
    .id_funct      (id_funct),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .flush         (flush),
    .exm_wen       (exm_wen),
    .exm_rd        (exm_rd),
    .exm_data      (exm_data),
    .mwb_wen       (mwb_wen),
    .mwb_rd        (mwb_rd),
    .mwb_data      (mwb_data),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_ctl        (ex_ctl),
    .ex_data_a     (ex_data_a),
    .ex_data_b     (ex_data_b),
    .ex_store_data (ex_store_data),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_branch     (ex_branch),
    .ex_illegal    (ex_illegal),
    .issued_cnt    (issued_cnt),
    .illegal_cnt   (illegal_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [31:0] rsd, input logic [4:0] rt, input logic [31:0] rtd,
                       input logic [4:0] rd, input logic [15:0] imm);
    id_valid   = 1'b1;
    id_opcode  = op;
    id_funct   = fn;
    id_rs      = rs;
    id_rs_data = rsd;
    id_rt      = rt;
    id_rt_data = rtd;
    id_rd      = rd;
    id_imm     = imm;
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_opcode = '0; id_funct = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; flush = 1'b0;
    exm_wen = 1'b0; exm_rd = '0; exm_data = '0; mwb_wen = 1'b0; mwb_rd = '0; mwb_data = '0;
    ex_ready = 1'b1;
    #2;
    check("rst_valid", ex_valid, 0);
    check("rst_ctl", ex_ctl, 0);
    check("rst_issued", issued_cnt, 0);
    check("rst_id_ready", id_ready, 1);
    step(); step();
    rst_n = 1'b1;
    step();

    // ADD r3 = r1(5) + r2(7)
    issue(6'h00, 6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 16'h0);
    step();
    check("add_valid", ex_valid, 1);
    check("add_ctl", ex_ctl, 3'b010);
    check("add_a", ex_data_a, 5);
    check("add_b", ex_data_b, 7);
    check("add_dest", ex_dest, 3);
    check("add_rw", ex_reg_write, 1);
    check("add_issued", issued_cnt, 1);

    // ANDI zero-extends, SLTI sign-extends
    issue(6'h0C, 6'h00, 5'd1, 32'd5, 5'd6, 32'd0, 5'd0, 16'hFFFF);
    step();
    check("andi_b", ex_data_b, 32'h0000FFFF);
    check("andi_ctl", ex_ctl, 3'b000);
    check("andi_dest", ex_dest, 6);
    issue(6'h0A, 6'h00, 5'd1, 32'd5, 5'd6, 32'd0, 5'd0, 16'hFFFF);
    step();
    check("slti_b", ex_data_b, 32'hFFFFFFFF);
    check("slti_ctl", ex_ctl, 3'b111);

    // Forwarding priority
    exm_wen = 1'b1; exm_rd = 5'd4; exm_data = 32'hAA;
    mwb_wen = 1'b1; mwb_rd = 5'd4; mwb_data = 32'hBB;
    issue(6'h00, 6'h20, 5'd4, 32'h11, 5'd2, 32'd7, 5'd3, 16'h0);
    step();
    check("fwd_exm_a", ex_data_a, 32'hAA);
    check("fwd_exm_b", ex_data_b, 7);
    exm_wen = 1'b0;
    step();
    check("fwd_mwb_a", ex_data_a, 32'hBB);
    exm_wen = 1'b1; exm_rd = 5'd0; mwb_wen = 1'b0;
    issue(6'h00, 6'h20, 5'd0, 32'h33, 5'd2, 32'd7, 5'd3, 16'h0);
    step();
    check("fwd_r0_a", ex_data_a, 32'h33);

    // Immediate B never forwarded; store data is forwarded rt
    exm_rd = 5'd4;
    issue(6'h08, 6'h00, 5'd1, 32'd5, 5'd4, 32'h44, 5'd0, 16'h0010);
    step();
    check("addi_b", ex_data_b, 32'h10);
    check("addi_dest", ex_dest, 4);
    check("addi_rw", ex_reg_write, 1);
    issue(6'h2B, 6'h00, 5'd1, 32'd5, 5'd4, 32'h44, 5'd0, 16'h0008);
    step();
    check("sw_b", ex_data_b, 32'h8);
    check("sw_store", ex_store_data, 32'hAA);
    check("sw_mw", ex_mem_write, 1);
    check("sw_rw", ex_reg_write, 0);
    exm_wen = 1'b0;

    // LW to r0: reg_write suppressed
    issue(6'h23, 6'h00, 5'd1, 32'd5, 5'd0, 32'd0, 5'd0, 16'h0004);
    step();
    check("lw_mr", ex_mem_read, 1);
    check("lw_r0_rw", ex_reg_write, 0);
    check("lw_ctl", ex_ctl, 3'b010);

    // BEQ
    issue(6'h04, 6'h00, 5'd1, 32'd5, 5'd2, 32'd7, 5'd0, 16'h0003);
    step();
    check("beq_ctl", ex_ctl, 3'b110);
    check("beq_b", ex_data_b, 7);
    check("beq_br", ex_branch, 1);
    check("beq_issued", issued_cnt, 10);

    // Back-pressure: hold three cycles, then release
    ex_ready = 1'b0;
    issue(6'h00, 6'h25, 5'd3, 32'h30, 5'd5, 32'h50, 5'd7, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_id_ready", id_ready, 0);
      check("stall_ctl", ex_ctl, 3'b110);
      check("stall_a", ex_data_a, 5);
    end
    check("stall_issued", issued_cnt, 10);
    ex_ready = 1'b1;
    step();
    check("rel_ctl", ex_ctl, 3'b001);
    check("rel_a", ex_data_a, 32'h30);
    check("rel_dest", ex_dest, 7);
    check("rel_issued", issued_cnt, 11);

    // Drain with no new instruction
    id_valid = 1'b0;
    step();
    check("drain_valid", ex_valid, 0);

    // Flush beats capture but capture still counts
    issue(6'h00, 6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 16'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", ex_valid, 0);
    check("flush_rw", ex_reg_write, 0);
    check("flush_issued", issued_cnt, 12);

    // Illegal opcode and illegal funct
    issue(6'h3F, 6'h00, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 16'h0);
    step();
    check("ill_flag", ex_illegal, 1);
    check("ill_rw", ex_reg_write, 0);
    check("ill_ctl", ex_ctl, 3'b010);
    check("ill_cnt", illegal_cnt, 1);
    issue(6'h00, 6'h21, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 16'h0);
    step();
    check("illfn_flag", ex_illegal, 1);
    check("illfn_cnt", illegal_cnt, 2);

    // Async reset mid-stream
    issue(6'h00, 6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 16'h0);
    step();
    check("pre_rst_valid", ex_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ex_valid, 0);
    check("mid_rst_a", ex_data_a, 0);
    check("mid_rst_rw", ex_reg_write, 0);
    check("mid_rst_issued", issued_cnt, 0);
    check("mid_rst_illegal", illegal_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
